kf8253_bus_initiator: RTL and testbench

KF8253_BUS_INITIATOR -- requirements
Module: kf8253_bus_initiator

---
 rtl/kf8253_bus_initiator.sv | 221 ++++++++++++++++++++++
 tb/tb_kf8253_bus_initiator.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kf8253_bus_initiator.sv
// Bus initiator that programs 8253 counters (and optionally reads counts back) over a strobed byte bus.
// Read-back path is present only when KF8253_INIT_READBACK_EN is defined.
module kf8253_bus_initiator #(
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [1:0]  req_channel,
  input  logic [2:0]  req_mode,
  input  logic        req_bcd,
  input  logic [15:0] req_count,
  output logic        rsp_valid,
  output logic        rsp_error,
  output logic [15:0] rsp_data,
  output logic        chip_select_n,
  output logic        read_enable_n,
  output logic        write_enable_n,
  output logic [1:0]  address,
  output logic [7:0]  data_bus_out,
  input  logic [7:0]  data_bus_in
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_e;

  localparam logic [15:0] StrobeLast = 16'(STROBE_CYCLES - 1);
  localparam logic [15:0] HoldLast   = 16'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  byte_q, byte_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [1:0]  ch_q, ch_d;
  logic [2:0]  mode_q, mode_d;
  logic        bcd_q, bcd_d;
  logic [15:0] count_q, count_d;
  logic [15:0] rsp_data_q, rsp_data_d;
`ifdef KF8253_INIT_READBACK_EN
  logic        op_q, op_d;
  logic [15:0] rd_q, rd_d;
`endif

  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_error_q, rsp_error_d;
  logic        cs_n_q, cs_n_d;
  logic        re_n_q, re_n_d;
  logic        we_n_q, we_n_d;
  logic [1:0]  addr_q, addr_d;
  logic [7:0]  dout_q, dout_d;

  logic        bus_active;
  logic        is_read;
  logic [7:0]  cmd_byte;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    byte_d     = byte_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    ch_d       = ch_q;
    mode_d     = mode_q;
    bcd_d      = bcd_q;
    count_d    = count_q;
    rsp_data_d = rsp_data_q;
`ifdef KF8253_INIT_READBACK_EN
    op_d       = op_q;
    rd_d       = rd_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = SETUP;
          byte_d  = 2'd0;
          cnt_d   = '0;
          ch_d    = req_channel;
          mode_d  = req_mode;
          bcd_d   = req_bcd;
          count_d = req_count;
`ifdef KF8253_INIT_READBACK_EN
          op_d    = req_op;
          err_d   = (req_channel == 2'd3);
`else
          err_d   = (req_channel == 2'd3) || req_op;
`endif
        end
      end
      // A rejected request passes through one silent SETUP clock before DONE.
      SETUP: begin
        cnt_d   = '0;
        state_d = err_q ? DONE : STROBE;
        if (err_q) rsp_data_d = '0;
      end
      STROBE: begin
        if (cnt_q == StrobeLast) begin
          state_d = HOLD;
          cnt_d   = '0;
`ifdef KF8253_INIT_READBACK_EN
          if (op_q && byte_q == 2'd1) rd_d[7:0]  = data_bus_in;
          if (op_q && byte_q == 2'd2) rd_d[15:8] = data_bus_in;
`endif
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      HOLD: begin
        if (cnt_q == HoldLast) begin
          cnt_d = '0;
          if (byte_q == 2'd2) begin
            state_d = DONE;
`ifdef KF8253_INIT_READBACK_EN
            if (op_q) rsp_data_d = rd_q;
`endif
          end else begin
            state_d = SETUP;
            byte_d  = byte_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are computed for the state being entered so they leave the flops aligned with it.
    bus_active = (state_d == SETUP || state_d == STROBE || state_d == HOLD) && !err_d;
`ifdef KF8253_INIT_READBACK_EN
    is_read  = op_d && (byte_d != 2'd0);
    cmd_byte = op_d ? {ch_d, 6'b000000} : {ch_d, 2'b11, mode_d, bcd_d};
`else
    is_read  = 1'b0;
    cmd_byte = {ch_d, 2'b11, mode_d, bcd_d};
`endif

    cs_n_d = !bus_active;
    we_n_d = !(bus_active && state_d == STROBE && !is_read);
    re_n_d = !(bus_active && state_d == STROBE && is_read);
    addr_d = '0;
    dout_d = '0;
    if (bus_active) begin
      addr_d = (byte_d == 2'd0) ? 2'd3 : ch_d;
      if (!is_read) begin
        unique case (byte_d)
          2'd0:    dout_d = cmd_byte;
          2'd1:    dout_d = count_d[7:0];
          default: dout_d = count_d[15:8];
        endcase
      end
    end

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == DONE);
    rsp_error_d = (state_d == DONE) && err_d;
  end

  // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      byte_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      ch_q        <= '0;
      mode_q      <= '0;
      bcd_q       <= 1'b0;
      count_q     <= '0;
      rsp_data_q  <= '0;
`ifdef KF8253_INIT_READBACK_EN
      op_q        <= 1'b0;
      rd_q        <= '0;
`endif
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      cs_n_q      <= 1'b1;
      re_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      addr_q      <= '0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      ch_q        <= ch_d;
      mode_q      <= mode_d;
      bcd_q       <= bcd_d;
      count_q     <= count_d;
      rsp_data_q  <= rsp_data_d;
`ifdef KF8253_INIT_READBACK_EN
      op_q        <= op_d;
      rd_q        <= rd_d;
`endif
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      cs_n_q      <= cs_n_d;
      re_n_q      <= re_n_d;
      we_n_q      <= we_n_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_error      = rsp_error_q;
  assign rsp_data       = rsp_data_q;
  assign chip_select_n  = cs_n_q;
  assign read_enable_n  = re_n_q;
  assign write_enable_n = we_n_q;
  assign address        = addr_q;
  assign data_bus_out   = dout_q;

endmodule

// File: tb/tb_kf8253_bus_initiator.sv
// Self-checking bench: a per-cycle expected-output trace built from transaction rules, plus literal pins.
module tb_kf8253_bus_initiator;

  localparam int S = 2;
  localparam int H = 1;
`ifdef KF8253_INIT_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_op = 1'b0;
  logic [1:0]  req_channel = '0;
  logic [2:0]  req_mode = '0;
  logic        req_bcd = 1'b0;
  logic [15:0] req_count = '0;
  logic        req_ready, rsp_valid, rsp_error;
  logic [15:0] rsp_data;
  logic        chip_select_n, read_enable_n, write_enable_n;
  logic [1:0]  address;
  logic [7:0]  data_bus_out, data_bus_in;

  kf8253_bus_initiator #(.STROBE_CYCLES(S), .HOLD_CYCLES(H)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_channel(req_channel), .req_mode(req_mode), .req_bcd(req_bcd), .req_count(req_count),
    .rsp_valid(rsp_valid), .rsp_error(rsp_error), .rsp_data(rsp_data),
    .chip_select_n(chip_select_n), .read_enable_n(read_enable_n), .write_enable_n(write_enable_n),
    .address(address), .data_bus_out(data_bus_out), .data_bus_in(data_bus_in)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        ready;
    logic        valid;
    logic        err;
    logic [15:0] data;
    logic        cs_n;
    logic        re_n;
    logic        we_n;
    logic [1:0]  addr;
    logic [7:0]  dout;
  } out_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Peripheral: counter values returned LSB first, MSB second after a latch command.
  logic [15:0] per_mem [4];
  logic        per_msb = 1'b0;
  logic        re_prev = 1'b1;
  initial per_mem = '{16'h0F0E, 16'h5A3C, 16'hABCD, 16'h0000};
  assign data_bus_in = per_msb ? per_mem[address][15:8] : per_mem[address][7:0];
  always @(posedge clock) begin
    re_prev <= read_enable_n;
    if (reset || (!write_enable_n && address == 2'd3)) per_msb <= 1'b0;
    else if (read_enable_n && !re_prev) per_msb <= ~per_msb;
  end

  // Model: queue of expected outputs, one entry per clock of the running transaction.
  out_t        exp_q[$];
  logic [15:0] m_rsp_data = '0;
  int          cyc = 0;
  int          n_acc = 0;
  int          acc_cyc[$];
  bit          started = 1'b0;

  function automatic out_t idle_out();
    out_t e;
    e = '{ready: 1'b1, valid: 1'b0, err: 1'b0, data: m_rsp_data, cs_n: 1'b1,
          re_n: 1'b1, we_n: 1'b1, addr: 2'd0, dout: 8'h00};
    return e;
  endfunction

  task automatic build_trace(input logic op, input logic [1:0] ch, input logic [2:0] mode,
                             input logic bcd, input logic [15:0] cnt);
    out_t       e;
    out_t       s;
    logic [7:0] wr [3];
    bit         err;
    bit         rd;
    err = (ch == 2'd3) || (op && !RB);
    e = idle_out();
    e.ready = 1'b0;
    if (err) begin
      exp_q.push_back(e);
      e.valid = 1'b1; e.err = 1'b1; e.data = 16'h0000;
      exp_q.push_back(e);
      return;
    end
    wr[0] = op ? {ch, 6'b000000} : {ch, 2'b11, mode, bcd};
    wr[1] = cnt[7:0];
    wr[2] = cnt[15:8];
    for (int b = 0; b < 3; b++) begin
      rd = op && (b > 0);
      e = idle_out();
      e.ready = 1'b0;
      e.cs_n  = 1'b0;
      e.addr  = (b == 0) ? 2'd3 : ch;
      e.dout  = rd ? 8'h00 : wr[b];
      exp_q.push_back(e);
      for (int i = 0; i < S; i++) begin
        s = e;
        if (rd) s.re_n = 1'b0; else s.we_n = 1'b0;
        exp_q.push_back(s);
      end
      for (int i = 0; i < H; i++) exp_q.push_back(e);
    end
    e = idle_out();
    e.ready = 1'b0;
    e.valid = 1'b1;
    e.data  = op ? per_mem[ch] : m_rsp_data;
    exp_q.push_back(e);
  endtask

  always @(posedge clock) begin
    out_t e;
    bit   idle;
    started = 1'b1;
    if (reset) begin
      exp_q.delete();
      m_rsp_data = '0;
    end else begin
      idle = (exp_q.size() == 0);
      if (!idle) begin
        e = exp_q.pop_front();
        if (e.valid) m_rsp_data = e.data;
      end
      if (idle && req_valid) begin
        acc_cyc.push_back(cyc);
        n_acc++;
        build_trace(req_op, req_channel, req_mode, req_bcd, req_count);
      end
    end
    cyc++;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    out_t act;
    out_t exp;
    if (started) begin
      act = '{ready: req_ready, valid: rsp_valid, err: rsp_error, data: rsp_data,
              cs_n: chip_select_n, re_n: read_enable_n, we_n: write_enable_n,
              addr: address, dout: data_bus_out};
      exp = (exp_q.size() > 0) ? exp_q[0] : idle_out();
      check("cycle_outputs", act, exp);
    end
  end

  // Observers feeding the literal checks.
  int          rsp_cnt = 0;
  int          last_lat = 0;
  logic        last_err = 1'b0;
  logic [15:0] last_data = '0;
  int          cs_low = 0;
  int          re_low = 0;
  logic        we_prev = 1'b1;
  int          we_len = 0;
  logic [9:0]  wr_log[$];
  int          we_lens[$];

  always @(negedge clock) begin
    if (started) begin
      if (rsp_valid) begin
        rsp_cnt++;
        last_lat  = (acc_cyc.size() > 0) ? cyc - acc_cyc[acc_cyc.size()-1] : -1;
        last_err  = rsp_error;
        last_data = rsp_data;
      end
      if (!chip_select_n) cs_low++;
      if (!read_enable_n) re_low++;
      if (!write_enable_n) begin
        if (we_prev) wr_log.push_back({address, data_bus_out});
        we_len++;
      end else if (!we_prev) begin
        we_lens.push_back(we_len);
        we_len = 0;
      end
      we_prev = write_enable_n;
    end
  end

  task automatic tick();
    @(negedge clock);
    #2;
  endtask

  task automatic issue(input logic op, input logic [1:0] ch, input logic [2:0] mode,
                       input logic bcd, input logic [15:0] cnt, input bit keep_valid);
    int n0;
    n0 = n_acc;
    req_op = op; req_channel = ch; req_mode = mode; req_bcd = bcd; req_count = cnt;
    req_valid = 1'b1;
    for (int i = 0; i < 40 && n_acc == n0; i++) tick();
    check("accepted", 32'(n_acc - n0), 32'd1);
    if (!keep_valid) req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int r0);
    for (int i = 0; i < 60 && rsp_cnt == r0; i++) tick();
    check("rsp_seen", 32'(rsp_cnt - r0), 32'd1);
    tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0;
    int cs0;
    int re0;
    repeat (3) tick();
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_bus", 32'({chip_select_n, read_enable_n, write_enable_n, address, data_bus_out}), 32'h00001C00);
    check("reset_rsp", 32'({rsp_valid, rsp_error, rsp_data}), 32'd0);
    reset = 1'b0;
    tick();

    // Program ch1 mode 2 bcd 0 count 1234.
    r0 = rsp_cnt; wr_log.delete(); we_lens.delete();
    issue(1'b0, 2'd1, 3'd2, 1'b0, 16'h1234, 1'b0);
    wait_rsp(r0);
    check("prog_latency", 32'(last_lat), 32'd13);
    check("prog_error", 32'(last_err), 32'd0);
    check("prog_nwrites", 32'(wr_log.size()), 32'd3);
    check("prog_w0", 32'(wr_log[0]), 32'({2'd3, 8'h74}));
    check("prog_w1", 32'(wr_log[1]), 32'({2'd1, 8'h34}));
    check("prog_w2", 32'(wr_log[2]), 32'({2'd1, 8'h12}));
    for (int i = 0; i < 3; i++) check("prog_we_len", 32'(we_lens[i]), 32'd2);

    // Program ch0 mode 3 bcd 1 leaves rsp_data untouched.
    r0 = rsp_cnt;
    issue(1'b0, 2'd0, 3'd3, 1'b1, 16'h00FF, 1'b0);
    wait_rsp(r0);
    check("prog2_data", 32'(last_data), 32'h0000);

    // Read back ch2.
    r0 = rsp_cnt; cs0 = cs_low; re0 = re_low; wr_log.delete();
    issue(1'b1, 2'd2, 3'd0, 1'b0, 16'h0000, 1'b0);
    wait_rsp(r0);
`ifdef KF8253_INIT_READBACK_EN
    check("rb_data", 32'(last_data), 32'h0000ABCD);
    check("rb_latch_cmd", 32'(wr_log[0]), 32'({2'd3, 8'h80}));
    check("rb_read_clocks", 32'(re_low - re0), 32'd4);
    check("rb_latency", 32'(last_lat), 32'd13);
`else
    check("rb_error", 32'(last_err), 32'd1);
    check("rb_no_read", 32'(re_low), 32'd0);
    check("rb_no_cs", 32'(cs_low - cs0), 32'd0);
    check("rb_latency", 32'(last_lat), 32'd2);
`endif

    // Read back ch1 then a program: rsp_data must survive the program.
    r0 = rsp_cnt;
    issue(1'b1, 2'd1, 3'd0, 1'b0, 16'h0000, 1'b0);
    wait_rsp(r0);
    r0 = rsp_cnt;
    issue(1'b0, 2'd2, 3'd0, 1'b0, 16'h0102, 1'b0);
    wait_rsp(r0);
    check("hold_data", 32'(rsp_data), RB ? 32'h00005A3C : 32'h0);

    // Illegal channel.
    r0 = rsp_cnt; cs0 = cs_low;
    issue(1'b0, 2'd3, 3'd1, 1'b0, 16'hBEEF, 1'b0);
    wait_rsp(r0);
    check("ch3_latency", 32'(last_lat), 32'd2);
    check("ch3_error", 32'(last_err), 32'd1);
    check("ch3_data", 32'(last_data), 32'd0);
    check("ch3_no_cs", 32'(cs_low - cs0), 32'd0);

    // req_valid held high with fields changing while busy.
    r0 = rsp_cnt;
    issue(1'b0, 2'd0, 3'd4, 1'b0, 16'h5566, 1'b1);
    issue(1'b0, 2'd2, 3'd5, 1'b1, 16'h7788, 1'b0);
    check("b2b_gap", 32'(acc_cyc[acc_cyc.size()-1] - acc_cyc[acc_cyc.size()-2]), 32'd14);
    wait_rsp(r0 + 1);

    // Reset during the second strobe clock.
    r0 = rsp_cnt;
    issue(1'b0, 2'd1, 3'd0, 1'b0, 16'h4321, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    check("rst_mid_bus", 32'({chip_select_n, read_enable_n, write_enable_n}), 32'h7);
    reset = 1'b0;
    repeat (20) tick();
    check("rst_mid_no_rsp", 32'(rsp_cnt - r0), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
